// File: rtl/wave_capture.sv
// Zero-crossing triggered capture of 2**DEPTH_LOG2 codec samples into the sample RAM
// half the display is not reading; the halves are swapped once the display goes idle.
module wave_capture #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH_LOG2   = 8,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    new_sample_ready_i,
    input  logic [SAMPLE_WIDTH-1:0] new_sample_in_i,
    input  logic                    wave_display_idle_i,
    output logic [DEPTH_LOG2:0]     write_address_o,
    output logic                    write_enable_o,
    output logic [OUT_WIDTH-1:0]    write_sample_o,
    output logic                    read_index_o
);

    // state  | meaning
    // ARMED  | watching for a rising zero crossing
    // ACTIVE | writing one sample per strobe until the half is full
    // WAIT   | capture done, waiting for display idle to swap halves
    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   index_q, index_d;
    logic [SAMPLE_WIDTH-1:0] prev_sample_q;
    logic                    read_index_q, read_index_d;
    logic                    write_enable_q, write_enable_d;
    logic [DEPTH_LOG2:0]     write_address_q, write_address_d;
    logic [OUT_WIDTH-1:0]    write_sample_q, write_sample_d;

    logic                    crossing;
    logic                    last_index;
    logic                    write_go;
    logic [DEPTH_LOG2-1:0]   write_index;
    logic [OUT_WIDTH-1:0]    converted;

    assign crossing   = new_sample_ready_i
                        && prev_sample_q[SAMPLE_WIDTH-1]
                        && !new_sample_in_i[SAMPLE_WIDTH-1];
    assign last_index = (index_q == {DEPTH_LOG2{1'b1}});
    // Offset binary: invert the sign bit of the top OUT_WIDTH bits.
    assign converted  = {~new_sample_in_i[SAMPLE_WIDTH-1],
                         new_sample_in_i[SAMPLE_WIDTH-2 -: OUT_WIDTH-1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ARMED;
            index_q         <= '0;
            prev_sample_q   <= '0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            state_q         <= state_d;
            index_q         <= index_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
            if (new_sample_ready_i) begin
                prev_sample_q <= new_sample_in_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMED: begin
                if (crossing) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready_i && last_index) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wave_display_idle_i) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_comb begin
        write_go     = 1'b0;
        write_index  = index_q;
        index_d      = index_q;
        read_index_d = read_index_q;
        unique case (state_q)
            ARMED: begin
                if (crossing) begin
                    write_go    = 1'b1;
                    write_index = '0;
                    index_d     = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                end
            end
            ACTIVE: begin
                if (new_sample_ready_i) begin
                    write_go = 1'b1;
                    index_d  = index_q + 1'b1;
                end
            end
            WAIT: begin
                if (wave_display_idle_i) begin
                    read_index_d = ~read_index_q;
                end
            end
            default: index_d = '0;
        endcase

        write_enable_d  = write_go;
        write_address_d = write_go ? {~read_index_q, write_index} : write_address_q;
        write_sample_d  = write_go ? converted : write_sample_q;
    end

    assign write_enable_o  = write_enable_q;
    assign write_address_o = write_address_q;
    assign write_sample_o  = write_sample_q;
    assign read_index_o    = read_index_q;

endmodule
